// File: rtl/bp_fpga_host_uart.sv
// Host-side UART: FSM transmitter, oversampled FSM receiver with an RX FIFO,
// and sticky parity / framing / overflow error flags.
module bp_fpga_host_uart #(
  parameter int clk_per_bit_p = 10416,
  parameter int data_bits_p   = 8,
  parameter int parity_bit_p  = 0,
  parameter int parity_odd_p  = 0,
  parameter int stop_bits_p   = 1,
  parameter int rx_fifo_els_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [data_bits_p-1:0] tx_data_i,
  input  logic                   tx_v_i,
  output logic                   tx_ready_and_o,
  output logic                   tx_o,
  input  logic                   rx_i,
  output logic [data_bits_p-1:0] rx_data_o,
  output logic                   rx_v_o,
  input  logic                   rx_yumi_i,
  output logic                   parity_err_o,
  output logic                   frame_err_o,
  output logic                   overflow_o,
  input  logic                   err_clear_i
);

  localparam int cnt_w  = $clog2(clk_per_bit_p);
  localparam int idx_w  = $clog2(data_bits_p);
  localparam int ptr_w  = $clog2(rx_fifo_els_p);
  localparam int fcnt_w = $clog2(rx_fifo_els_p + 1);

  localparam logic             odd_l       = (parity_odd_p != 0);
  localparam logic             par_en_l    = (parity_bit_p != 0);
  localparam logic [cnt_w-1:0] bit_last_l  = cnt_w'(clk_per_bit_p - 1);
  localparam logic [cnt_w-1:0] half_last_l = cnt_w'(clk_per_bit_p / 2 - 1);
  localparam logic [idx_w-1:0] data_last_l = idx_w'(data_bits_p - 1);
  localparam logic [idx_w-1:0] stop_last_l = idx_w'(stop_bits_p - 1);
  localparam logic [ptr_w-1:0] ptr_last_l  = ptr_w'(rx_fifo_els_p - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                 tx_state, tx_state_n;
  logic [cnt_w-1:0]       tx_cnt, tx_cnt_n;
  logic [idx_w-1:0]       tx_idx, tx_idx_n;
  logic [data_bits_p-1:0] tx_shift, tx_shift_n;
  logic                   tx_par, tx_par_n;
  logic                   tx_armed;
  logic                   tx_bit_done;

  // tx_armed keeps ready low during reset and raises it on the first edge after.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_armed <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_armed <= 1'b1;
    end
  end

  assign tx_ready_and_o = tx_armed & (tx_state == IDLE);
  assign tx_bit_done    = (tx_cnt == bit_last_l);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_o       = 1'b1;
    if (tx_state != IDLE) tx_cnt_n = tx_bit_done ? '0 : tx_cnt + 1'b1;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        if (tx_v_i && tx_ready_and_o) begin
          tx_state_n = START;
          tx_shift_n = tx_data_i;
          tx_par_n   = (^tx_data_i) ^ odd_l;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (tx_bit_done) begin
          tx_state_n = DATA;
          tx_idx_n   = '0;
        end
      end
      DATA: begin
        tx_o = tx_shift[0];
        if (tx_bit_done) begin
          tx_shift_n = tx_shift >> 1;
          if (tx_idx == data_last_l) begin
            tx_state_n = par_en_l ? PARITY : STOP;
            tx_idx_n   = '0;
          end else begin
            tx_idx_n = tx_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        tx_o = tx_par;
        if (tx_bit_done) begin
          tx_state_n = STOP;
          tx_idx_n   = '0;
        end
      end
      STOP: begin
        if (tx_bit_done) begin
          if (tx_idx == stop_last_l) tx_state_n = IDLE;
          else tx_idx_n = tx_idx + 1'b1;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  logic [1:0] rx_sync;
  logic       rx_s, rx_prev;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_i};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = rx_sync[1];

  state_e                 rx_state, rx_state_n;
  logic [cnt_w-1:0]       rx_cnt, rx_cnt_n;
  logic [idx_w-1:0]       rx_idx, rx_idx_n;
  logic [data_bits_p-1:0] rx_shift, rx_shift_n;
  logic                   rx_par_bad, rx_par_bad_n;
  logic                   rx_stop_bad, rx_stop_bad_n;
  logic                   rx_push, rx_push_n;
  logic                   rx_perr_ev, rx_perr_ev_n;
  logic                   rx_ferr_ev, rx_ferr_ev_n;
  logic                   rx_sample;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_state    <= IDLE;
      rx_cnt      <= '0;
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_par_bad  <= 1'b0;
      rx_stop_bad <= 1'b0;
      rx_push     <= 1'b0;
      rx_perr_ev  <= 1'b0;
      rx_ferr_ev  <= 1'b0;
    end else begin
      rx_state    <= rx_state_n;
      rx_cnt      <= rx_cnt_n;
      rx_idx      <= rx_idx_n;
      rx_shift    <= rx_shift_n;
      rx_par_bad  <= rx_par_bad_n;
      rx_stop_bad <= rx_stop_bad_n;
      rx_push     <= rx_push_n;
      rx_perr_ev  <= rx_perr_ev_n;
      rx_ferr_ev  <= rx_ferr_ev_n;
    end
  end

  // Start bit is checked at half a bit; every later bit one full bit after that.
  assign rx_sample = (rx_state == START) ? (rx_cnt == half_last_l) : (rx_cnt == bit_last_l);

  always_comb begin
    rx_state_n    = rx_state;
    rx_cnt_n      = rx_sample ? '0 : rx_cnt + 1'b1;
    rx_idx_n      = rx_idx;
    rx_shift_n    = rx_shift;
    rx_par_bad_n  = rx_par_bad;
    rx_stop_bad_n = rx_stop_bad;
    rx_push_n     = 1'b0;
    rx_perr_ev_n  = 1'b0;
    rx_ferr_ev_n  = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s) begin
          rx_state_n    = START;
          rx_par_bad_n  = 1'b0;
          rx_stop_bad_n = 1'b0;
        end
      end
      START: begin
        if (rx_sample) begin
          rx_state_n = rx_s ? IDLE : DATA;
          rx_idx_n   = '0;
        end
      end
      DATA: begin
        if (rx_sample) begin
          rx_shift_n = {rx_s, rx_shift[data_bits_p-1:1]};
          if (rx_idx == data_last_l) begin
            rx_state_n = par_en_l ? PARITY : STOP;
            rx_idx_n   = '0;
          end else begin
            rx_idx_n = rx_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (rx_sample) begin
          rx_par_bad_n = (^rx_shift) ^ odd_l ^ rx_s;
          rx_state_n   = STOP;
          rx_idx_n     = '0;
        end
      end
      STOP: begin
        if (rx_sample) begin
          rx_stop_bad_n = rx_stop_bad | ~rx_s;
          if (rx_idx == stop_last_l) begin
            rx_state_n   = IDLE;
            rx_push_n    = ~rx_par_bad & ~rx_stop_bad_n;
            rx_perr_ev_n = rx_par_bad;
            rx_ferr_ev_n = rx_stop_bad_n;
          end else begin
            rx_idx_n = rx_idx + 1'b1;
          end
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  logic [data_bits_p-1:0] fifo_mem [rx_fifo_els_p];
  logic [ptr_w-1:0]       rd_ptr, wr_ptr;
  logic [fcnt_w-1:0]      fifo_cnt;
  logic                   fifo_full, fifo_pop, fifo_push;

  assign fifo_full = (fifo_cnt == fcnt_w'(rx_fifo_els_p));
  assign fifo_pop  = rx_yumi_i & rx_v_o;
  assign fifo_push = rx_push & (~fifo_full | fifo_pop);
  assign rx_v_o    = (fifo_cnt != '0);
  assign rx_data_o = fifo_mem[rd_ptr];

  // rx_shift is stable in IDLE, so it serves directly as the enqueue data.
  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= (wr_ptr == ptr_last_l) ? '0 : wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= (rd_ptr == ptr_last_l) ? '0 : rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // A set event wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      parity_err_o <= (parity_err_o & ~err_clear_i) | rx_perr_ev;
      frame_err_o  <= (frame_err_o & ~err_clear_i) | rx_ferr_ev;
      overflow_o   <= (overflow_o & ~err_clear_i) | (rx_push & fifo_full & ~fifo_pop);
    end
  end

endmodule
